// File: rtl/fifo.sv
// Synchronous single-clock FIFO with registered read data.
// Async active-low reset clears pointers, count and rd_data.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_val
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic we;
  logic re;

  assign wr_ready = (count_q != FULL);
  assign rd_val   = (count_q != '0);

  assign we = wr_en & wr_ready;
  assign re = rd_en & rd_val;

  assign rd_data = rd_data_q;

  // Next-state for pointers, occupancy and the read data register.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (we) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (re) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    unique case ({we, re})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards contents by clearing pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage array; left unreset since stale words are unreachable.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo.
// Default parameters: 8 bits wide, 8 entries.
module tb_fifo;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_val;

  int tests;
  int fails;

  fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_val   (rd_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic w,
                      input logic [7:0] d,
                      input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = 8'd0;
    reset   = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("rst_wr_ready", {7'd0, wr_ready}, 8'd1);
    chk("rst_rd_val", {7'd0, rd_val}, 8'd0);
    chk("rst_rd_data", rd_data, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;

    // single write then read
    step(1'b1, 8'd10, 1'b0);
    chk("w10_rd_val", {7'd0, rd_val}, 8'd1);
    chk("w10_wr_ready", {7'd0, wr_ready}, 8'd1);
    step(1'b0, 8'd0, 1'b1);
    chk("r10_data", rd_data, 8'b00001010);
    chk("r10_rd_val", {7'd0, rd_val}, 8'd0);
    chk("r10_wr_ready", {7'd0, wr_ready}, 8'd1);

    // fill to full
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0);
    end
    chk("full_wr_ready", {7'd0, wr_ready}, 8'd0);
    chk("full_rd_val", {7'd0, rd_val}, 8'd1);
    step(1'b1, 8'd99, 1'b0);
    chk("full_w99_wr_ready", {7'd0, wr_ready}, 8'd0);
    // full: read accepted, write refused
    step(1'b1, 8'd99, 1'b1);
    chk("full_rw_data", rd_data, 8'd1);
    chk("full_rw_wr_ready", {7'd0, wr_ready}, 8'd1);
    for (int i = 2; i <= 8; i++) begin
      step(1'b0, 8'd0, 1'b1);
      chk("drain_data", rd_data, 8'(i));
    end
    chk("drain_rd_val", {7'd0, rd_val}, 8'd0);
    chk("drain_wr_ready", {7'd0, wr_ready}, 8'd1);

    // empty read keeps rd_data
    step(1'b1, 8'd5, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    chk("r5_data", rd_data, 8'd5);
    step(1'b0, 8'd0, 1'b1);
    chk("empty_rd_data", rd_data, 8'd5);
    chk("empty_rd_val", {7'd0, rd_val}, 8'd0);
    // empty: write accepted, read refused
    step(1'b1, 8'd33, 1'b1);
    chk("empty_rw_data", rd_data, 8'd5);
    chk("empty_rw_rd_val", {7'd0, rd_val}, 8'd1);
    step(1'b0, 8'd0, 1'b1);
    chk("r33_data", rd_data, 8'd33);
    chk("r33_rd_val", {7'd0, rd_val}, 8'd0);

    // simultaneous read/write with 3 stored
    step(1'b1, 8'd40, 1'b0);
    step(1'b1, 8'd41, 1'b0);
    step(1'b1, 8'd42, 1'b0);
    step(1'b1, 8'd50, 1'b1);
    chk("rw0_data", rd_data, 8'd40);
    chk("rw0_flags", {6'd0, wr_ready, rd_val}, 8'd3);
    step(1'b1, 8'd51, 1'b1);
    chk("rw1_data", rd_data, 8'd41);
    chk("rw1_flags", {6'd0, wr_ready, rd_val}, 8'd3);
    step(1'b1, 8'd52, 1'b1);
    chk("rw2_data", rd_data, 8'd42);
    chk("rw2_flags", {6'd0, wr_ready, rd_val}, 8'd3);
    step(1'b1, 8'd53, 1'b1);
    chk("rw3_data", rd_data, 8'd50);
    chk("rw3_flags", {6'd0, wr_ready, rd_val}, 8'd3);
    step(1'b0, 8'd0, 1'b1);
    chk("rwd0_data", rd_data, 8'd51);
    step(1'b0, 8'd0, 1'b1);
    chk("rwd1_data", rd_data, 8'd52);
    step(1'b0, 8'd0, 1'b1);
    chk("rwd2_data", rd_data, 8'd53);
    chk("rwd_rd_val", {7'd0, rd_val}, 8'd0);

    // wrap: push 6, pop 6, push 8, pop 8
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'(60 + i), 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'd0, 1'b1);
      chk("wrap_pre_data", rd_data, 8'(60 + i));
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(20 + i), 1'b0);
    end
    chk("wrap_full", {7'd0, wr_ready}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'd0, 1'b1);
      chk("wrap_data", rd_data, 8'(20 + i));
    end
    chk("wrap_rd_val", {7'd0, rd_val}, 8'd0);

    // async reset mid-operation with 4 stored
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'(70 + i), 1'b0);
    end
    chk("pre_rst_rd_val", {7'd0, rd_val}, 8'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_rd_val", {7'd0, rd_val}, 8'd0);
    chk("arst_wr_ready", {7'd0, wr_ready}, 8'd1);
    chk("arst_rd_data", rd_data, 8'd0);
    wr_en   = 1'b1;
    wr_data = 8'd77;
    rd_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("in_rst_rd_val", {7'd0, rd_val}, 8'd0);
    chk("in_rst_rd_data", rd_data, 8'd0);
    reset = 1'b1;
    step(1'b0, 8'd0, 1'b1);
    chk("post_rst_rd_data", rd_data, 8'd0);
    chk("post_rst_rd_val", {7'd0, rd_val}, 8'd0);
    step(1'b1, 8'd88, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    chk("post_rst_r88", rd_data, 8'd88);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
